// File: rtl/mult_rr_scheduler.sv
// rtl/mult_rr_scheduler.sv - round-robin scheduler sharing one 8x8 multiplier between NREQ requesters
module mult_rr_scheduler #(
   parameter  int NREQ = 4,
   localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_a,
   input  logic [8*NREQ-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ID_W-1:0]   rsp_id,
   output logic [15:0]       rsp_prod,
   output logic              busy,
   output logic [15:0]       op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [7:0]      op_a_q, op_a_d;
   logic [7:0]      op_b_q, op_b_d;
   logic [ID_W-1:0] op_id_q, op_id_d;
   logic [15:0]     rsp_prod_q, rsp_prod_d;
   logic [ID_W-1:0] rsp_id_q, rsp_id_d;
   logic [15:0]     op_count_q, op_count_d;

   logic            grant_found;
   logic [ID_W-1:0] grant_id;
   logic [7:0]      grant_a;
   logic [7:0]      grant_b;
   logic [15:0]     mult_prod;

   // round-robin search starting at rr_ptr; first valid requester wins
   always_comb begin
      int idx;
      grant_found = 1'b0;
      grant_id    = '0;
      grant_a     = '0;
      grant_b     = '0;
      idx         = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NREQ;
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant_id    = ID_W'(idx);
            grant_a     = req_a[8*idx +: 8];
            grant_b     = req_b[8*idx +: 8];
         end
      end
   end

   // the single shared combinational multiplier, fed only from the registered operands
   always_comb begin
      mult_prod = 16'(op_a_q) * 16'(op_b_q);
   end

   // next-state and datapath updates for the IDLE -> CALC -> RESP sequence
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      op_id_d    = op_id_q;
      rsp_prod_d = rsp_prod_q;
      rsp_id_d   = rsp_id_q;
      op_count_d = op_count_q;
      req_ready  = '0;
      case (state_q)
         IDLE: begin
            if (grant_found) begin
               req_ready[grant_id] = 1'b1;
               op_a_d   = grant_a;
               op_b_d   = grant_b;
               op_id_d  = grant_id;
               rr_ptr_d = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + ID_W'(1);
               state_d  = CALC;
            end
         end
         CALC: begin
            rsp_prod_d = mult_prod;
            rsp_id_d   = op_id_q;
            state_d    = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               op_count_d = op_count_q + 16'd1;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and datapath registers; reset discards any in-flight transaction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_id_q    <= '0;
         rsp_prod_q <= '0;
         rsp_id_q   <= '0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         op_id_q    <= op_id_d;
         rsp_prod_q <= rsp_prod_d;
         rsp_id_q   <= rsp_id_d;
         op_count_q <= op_count_d;
      end
   end

   // outputs decoded directly from registered state
   always_comb begin
      rsp_valid = (state_q == RESP);
      busy      = (state_q != IDLE);
      rsp_prod  = rsp_prod_q;
      rsp_id    = rsp_id_q;
      op_count  = op_count_q;
   end

endmodule
